// File: rtl/ga23_tile_fetch_if.sv
// Bus bundle for ga23_tile_fetch: descriptor input, arbiter request/response
// and the serialised pixel stream to the layer pipeline.
interface ga23_tile_fetch_if;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_code;
    logic [2:0]  desc_row;
    logic        desc_flipx;
    logic        desc_flipy;
    logic [6:0]  desc_pal;

    logic [21:0] mem_addr;
    logic        mem_req;
    logic        mem_rdy;
    logic [31:0] mem_data;

    logic        pix_advance;
    logic        pix_valid;
    logic [3:0]  pix_color;
    logic [6:0]  pix_pal;

    modport slave (
        input  desc_valid, desc_code, desc_row, desc_flipx, desc_flipy, desc_pal,
        output desc_ready,
        output mem_addr, mem_req,
        input  mem_rdy, mem_data,
        input  pix_advance,
        output pix_valid, pix_color, pix_pal
    );

    modport master (
        output desc_valid, desc_code, desc_row, desc_flipx, desc_flipy, desc_pal,
        input  desc_ready,
        input  mem_addr, mem_req,
        output mem_rdy, mem_data,
        output pix_advance,
        input  pix_valid, pix_color, pix_pal
    );
endinterface

// File: rtl/ga23_tile_fetch.sv
// Per-layer tile row fetcher: one ROM read per tile row, rows buffered in a
// small FIFO and replayed as 4-bit pixels with palette.
module ga23_tile_fetch #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    ga23_tile_fetch_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state;
    logic [21:0]   addr_q;
    logic [6:0]    pal_q;
    logic          flipx_q;
    logic          discard;

    logic [31:0]   fifo_data [DEPTH];
    logic [6:0]    fifo_pal  [DEPTH];
    logic          fifo_flip [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [2:0]    pix_idx;

    logic          accept;
    logic          push;
    logic          pop;
    logic [2:0]    sel;
    logic [31:0]   head;

    // Accepting only in IDLE with room guarantees the single in-flight row always fits.
    assign bus.desc_ready = (state == S_IDLE) && (count < FULL) && !flush && !reset;
    assign accept         = bus.desc_valid && bus.desc_ready;
    assign push           = (state == S_WAIT) && bus.mem_rdy && !discard && !flush && !reset;
    assign bus.pix_valid  = (count != '0);
    assign pop            = bus.pix_valid && bus.pix_advance && (pix_idx == 3'd7);

    assign bus.mem_req  = (state == S_REQ);
    assign bus.mem_addr = addr_q;

    // Flipped rows walk the nibbles from the top; 7-n is just the bitwise inverse.
    assign head          = fifo_data[rd_ptr];
    assign sel           = fifo_flip[rd_ptr] ? ~pix_idx : pix_idx;
    assign bus.pix_color = bus.pix_valid ? head[{sel, 2'b00} +: 4] : 4'd0;
    assign bus.pix_pal   = bus.pix_valid ? fifo_pal[rd_ptr] : 7'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            discard <= 1'b0;
            addr_q  <= '0;
            pal_q   <= '0;
            flipx_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= {1'b0, bus.desc_code,
                                    bus.desc_row ^ {3{bus.desc_flipy}}, 2'b00};
                        pal_q   <= bus.desc_pal;
                        flipx_q <= bus.desc_flipx;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_WAIT;
                    if (flush) discard <= 1'b1;
                end
                S_WAIT: begin
                    // A flushed fetch must still retire so the arbiter stays in step.
                    if (bus.mem_rdy) begin
                        state   <= S_IDLE;
                        discard <= 1'b0;
                    end else if (flush) begin
                        discard <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pix_idx <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
            if (bus.pix_valid && bus.pix_advance) pix_idx <= pix_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_data;
            fifo_pal[wr_ptr]  <= pal_q;
            fifo_flip[wr_ptr] <= flipx_q;
        end
    end

endmodule
